// File: rtl/mips_pkg.sv
// Shared MIPS pipeline encodings: result-source classes, ID forwarding-mux codes
// and the destination tag carried down the hazard controller's private pipeline.
package mips_pkg;

  typedef enum logic [1:0] {
    WSRC_ALU = 2'd0,
    WSRC_MEM = 2'd1,
    WSRC_PC8 = 2'd2,
    WSRC_EXT = 2'd3
  } wsrc_e;

  typedef enum logic [2:0] {
    FWD_GPR      = 3'd0,
    FWD_EXT_EX   = 3'd1,
    FWD_EXT_MEM  = 3'd2,
    FWD_ALU_MEM  = 3'd3,
    FWD_EXT_WB   = 3'd4,
    FWD_ALU_WB   = 3'd5,
    FWD_MEMRD_WB = 3'd6
  } fwd_e;

  typedef struct packed {
    logic       v;
    logic [4:0] A3;
    wsrc_e      wsrc;
  } tag_t;

  function automatic logic tag_hit(input tag_t t, input logic [4:0] r);
    return t.v && (t.A3 != 5'd0) && (t.A3 == r);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding decision: nearest live producer wins (EX > MEM > WB);
// results not yet available at that stage request a stall instead of a code.
module hazard_fwd_sel
  import mips_pkg::*;
(
  input  logic [4:0] r,
  input  logic       use_r,
  input  tag_t       tag_ex,
  input  tag_t       tag_mem,
  input  tag_t       tag_wb,
  output fwd_e       code,
  output logic       stall
);

  always_comb begin
    code  = FWD_GPR;
    stall = 1'b0;
    if (use_r && (r != 5'd0)) begin
      if (tag_hit(tag_ex, r)) begin
        if (tag_ex.wsrc == WSRC_EXT) code  = FWD_EXT_EX;
        else                         stall = 1'b1;
      end else if (tag_hit(tag_mem, r)) begin
        case (tag_mem.wsrc)
          WSRC_EXT: code  = FWD_EXT_MEM;
          WSRC_ALU: code  = FWD_ALU_MEM;
          default:  stall = 1'b1;
        endcase
      end else if (tag_hit(tag_wb, r)) begin
        // jal in WB: the GPR holds the link value on the next read
        case (tag_wb.wsrc)
          WSRC_EXT: code  = FWD_EXT_WB;
          WSRC_ALU: code  = FWD_ALU_WB;
          WSRC_MEM: code  = FWD_MEMRD_WB;
          default:  stall = 1'b1;
        endcase
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: EX/MEM/WB destination-tag pipeline, ID forward
// selects and stall/bubble. Optional stall counter under `HAZARD_PERF_EN.
module hazard_ctrl
  import mips_pkg::*;
`ifdef HAZARD_PERF_EN
#(
  parameter int unsigned CNT_W = 32
)
`endif
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_ID,
  input  logic [4:0] rt_ID,
  input  logic       use_rs_ID,
  input  logic       use_rt_ID,
  input  logic       RegWrite_ID,
  input  logic [4:0] A3_ID,
  input  logic [1:0] wsrc_ID,
  output logic [2:0] Rd1_Fwd_ctr,
  output logic [2:0] Rd2_Fwd_ctr,
  output logic       stall_ID,
  output logic       bubble_EX
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  tag_t r_ex, r_mem, r_wb;
  fwd_e w_code_rs, w_code_rt;
  logic w_stall_rs, w_stall_rt;

  // A stalled ID instruction enters EX as an invalid tag (bubble)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_ex  <= '{v: RegWrite_ID & ~stall_ID, A3: A3_ID, wsrc: wsrc_e'(wsrc_ID)};
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  hazard_fwd_sel u_sel_rs (
    .r       (rs_ID),
    .use_r   (use_rs_ID),
    .tag_ex  (r_ex),
    .tag_mem (r_mem),
    .tag_wb  (r_wb),
    .code    (w_code_rs),
    .stall   (w_stall_rs)
  );

  hazard_fwd_sel u_sel_rt (
    .r       (rt_ID),
    .use_r   (use_rt_ID),
    .tag_ex  (r_ex),
    .tag_mem (r_mem),
    .tag_wb  (r_wb),
    .code    (w_code_rt),
    .stall   (w_stall_rt)
  );

  always_comb begin
    Rd1_Fwd_ctr = w_code_rs;
    Rd2_Fwd_ctr = w_code_rt;
    stall_ID    = w_stall_rs | w_stall_rt;
    bubble_EX   = w_stall_rs | w_stall_rt;
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_stall_cnt <= '0;
    else if (stall_ID && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl: one ID instruction per vector,
// plus hand-written asynchronous-reset sequence.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_ID, rt_ID, A3_ID;
  logic       use_rs_ID, use_rt_ID, RegWrite_ID;
  logic [1:0] wsrc_ID;
  logic [2:0] Rd1_Fwd_ctr, Rd2_Fwd_ctr;
  logic       stall_ID, bubble_EX;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
`endif

  hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .rs_ID       (rs_ID),
    .rt_ID       (rt_ID),
    .use_rs_ID   (use_rs_ID),
    .use_rt_ID   (use_rt_ID),
    .RegWrite_ID (RegWrite_ID),
    .A3_ID       (A3_ID),
    .wsrc_ID     (wsrc_ID),
    .Rd1_Fwd_ctr (Rd1_Fwd_ctr),
    .Rd2_Fwd_ctr (Rd2_Fwd_ctr),
    .stall_ID    (stall_ID),
    .bubble_EX   (bubble_EX)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       rw;
    logic [4:0] a3;
    logic [1:0] ws;
    logic [2:0] c1;
    logic [2:0] c2;
    logic       st;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs[NV];
  int total = 0;
  int bad   = 0;
  int exp_stalls = 0;

  function automatic vec_t mk(input string n, input int rs, input int rt, input int urs,
                              input int urt, input int rw, input int a3, input int ws,
                              input int c1, input int c2, input int st);
    vec_t v;
    v.name = n;   v.rs = 5'(rs); v.rt = 5'(rt); v.urs = 1'(urs); v.urt = 1'(urt);
    v.rw = 1'(rw); v.a3 = 5'(a3); v.ws = 2'(ws);
    v.c1 = 3'(c1); v.c2 = 3'(c2); v.st = 1'(st);
    return v;
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rs_ID = v.rs; rt_ID = v.rt; use_rs_ID = v.urs; use_rt_ID = v.urt;
    RegWrite_ID = v.rw; A3_ID = v.a3; wsrc_ID = v.ws;
  endtask

  task automatic run_vec(input vec_t v);
    drive(v);
    @(negedge clk);
    chk({v.name, ".stall"}, int'(stall_ID), int'(v.st));
    chk({v.name, ".bubble"}, int'(bubble_EX), int'(v.st));
    if (!v.st) begin
      chk({v.name, ".rd1"}, int'(Rd1_Fwd_ctr), int'(v.c1));
      chk({v.name, ".rd2"}, int'(Rd2_Fwd_ctr), int'(v.c2));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t nop, lw8, use8;
    nop  = mk("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lw8  = mk("rst_lw", 29, 0, 1, 0, 1, 8, 1, 0, 0, 0);
    use8 = mk("rst_use", 8, 8, 1, 1, 0, 0, 0, 0, 0, 1);

    // ALU chain; rs==rt hazard gives a single stall
    vecs[0]  = mk("alu_prod",   1, 2, 1, 1, 1, 8, 0, 0, 0, 0);
    vecs[1]  = mk("alu_st",     8, 8, 1, 1, 1, 9, 0, 0, 0, 1);
    vecs[2]  = mk("alu_mem",    8, 8, 1, 1, 1, 9, 0, 3, 3, 0);
    vecs[3]  = mk("alu_wb",     8, 0, 1, 1, 0, 0, 0, 5, 0, 0);
    vecs[4]  = nop;
    vecs[5]  = nop;
    // load-use
    vecs[6]  = mk("lw",        29, 0, 1, 0, 1, 8, 1, 0, 0, 0);
    vecs[7]  = mk("ld_st_ex",   1, 8, 1, 1, 1, 10, 0, 0, 0, 1);
    vecs[8]  = mk("ld_st_mem",  1, 8, 1, 1, 1, 10, 0, 0, 0, 1);
    vecs[9]  = mk("ld_wb",      1, 8, 1, 1, 1, 10, 0, 0, 6, 0);
    vecs[10] = nop;
    vecs[11] = nop;
    vecs[12] = nop;
    // lui forwarding from every stage
    vecs[13] = mk("lui",        0, 0, 0, 0, 1, 8, 3, 0, 0, 0);
    vecs[14] = mk("lui_ex",     8, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    vecs[15] = mk("lui_mem",    0, 8, 0, 1, 0, 0, 0, 0, 2, 0);
    vecs[16] = mk("lui_wb",     8, 8, 1, 1, 0, 0, 0, 4, 4, 0);
    // priority: addu r8 in MEM beats lui r8 in WB
    vecs[17] = mk("pri_lui",    0, 0, 0, 0, 1, 8, 3, 0, 0, 0);
    vecs[18] = mk("pri_addu",   0, 0, 0, 0, 1, 8, 0, 0, 0, 0);
    vecs[19] = nop;
    vecs[20] = mk("pri_use",    8, 0, 1, 0, 0, 0, 0, 3, 0, 0);
    // writes to r0 never forward or stall
    vecs[21] = mk("r0_lw",      0, 0, 1, 1, 1, 0, 1, 0, 0, 0);
    vecs[22] = mk("r0_ex",      0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    vecs[23] = mk("r0_mem",     0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    vecs[24] = mk("r0_wb",      0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    // jal r31 then jr r31
    vecs[25] = mk("jal",        0, 0, 0, 0, 1, 31, 2, 0, 0, 0);
    vecs[26] = mk("jr_st_ex",  31, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    vecs[27] = mk("jr_st_mem", 31, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    vecs[28] = mk("jr_st_wb",  31, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    vecs[29] = mk("jr_gpr",    31, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset with a live-tag pattern on the inputs
    rst = 1'b0;
    drive(use8);
    RegWrite_ID = 1'b1; A3_ID = 5'd8; wsrc_ID = 2'd1;
    #2;
    chk("rst_stall", int'(stall_ID), 0);
    chk("rst_rd1", int'(Rd1_Fwd_ctr), 0);
    chk("rst_rd2", int'(Rd2_Fwd_ctr), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_vec(lw8);
    // Mid-stall reset: stall must drop without waiting for a clock
    drive(use8);
    #2;
    chk("pre_rst_stall", int'(stall_ID), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_stall", int'(stall_ID), 0);
    chk("mid_rst_bubble", int'(bubble_EX), 0);
    chk("mid_rst_rd2", int'(Rd2_Fwd_ctr), 0);
`ifdef HAZARD_PERF_EN
    chk("mid_rst_cnt", int'(stall_cnt), 0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      vec_t v;
      v = use8;
      v.name = "post_rst_idle";
      v.st = 1'b0;
      run_vec(v);
    end

    for (int unsigned i = 0; i < NV; i++) begin
      run_vec(vecs[i]);
      if (vecs[i].st) exp_stalls++;
    end

`ifdef HAZARD_PERF_EN
    chk("stall_cnt", int'(stall_cnt), exp_stalls);
`endif
    chk("final_stall", int'(stall_ID), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
